// File: rtl/imem_param_if.sv
// Load port of the instruction memory: word-by-word program writes with a
// valid/ready handshake and a sticky error flag for rejected requests.
interface imem_param_if #(
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;

    // Boot loader / bench side
    modport master (
        output ld_valid,
        output ld_addr,
        output ld_data,
        input  ld_ready,
        input  ld_err
    );

    // Memory side
    modport slave (
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        output ld_ready,
        output ld_err
    );
endinterface

// File: rtl/imem_param.sv
// Parametrised instruction memory: combinational fetch port, clocked load port,
// and a post-reset clear sequencer that fills every word with INIT_WORD.
module imem_param #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       A,
    output logic [DATA_W-1:0] D,
    output logic              misaligned,
    output logic              out_of_range,
    output logic              init_done,
    imem_param_if.slave       ld
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("imem_param: DEPTH must be a power of two in 2..65536");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [AW-1:0]     clr_idx_reg;
    logic [AW-1:0]     clr_idx_next;
    logic              ld_err_reg;
    logic              ld_err_next;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     a_idx;
    logic [AW-1:0]     ld_idx;
    logic              ld_ok;

    // Address decode: word index from bits above the byte offset; any set bit
    // above the index field puts the address past DEPTH*4.
    assign a_idx        = A[AW+1:2];
    assign misaligned   = (A[1:0] != 2'b00);
    assign out_of_range = |A[31:AW+2];

    assign ld_idx = ld.ld_addr[AW+1:2];
    assign ld_ok  = (ld.ld_addr[1:0] == 2'b00) && !(|ld.ld_addr[31:AW+2]);

    assign init_done   = (state_reg == ST_IDLE);
    assign ld.ld_ready = (state_reg == ST_IDLE);
    assign ld.ld_err   = ld_err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
            ld_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
            ld_err_reg  <= ld_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        ld_err_next  = ld_err_reg;
        mem_we       = 1'b0;
        mem_waddr    = clr_idx_reg;
        mem_wdata    = INIT_WORD;

        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == AW'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ld.ld_valid) begin
                    if (ld_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = ld_idx;
                        mem_wdata = ld.ld_data;
                    end else begin
                        ld_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // Array has no reset; an edge seen while rst is low must not write.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        D = INIT_WORD;
        if (state_reg == ST_IDLE && !out_of_range) begin
            D = mem[a_idx];
        end
    end
endmodule

// File: tb/tb_imem_param.sv
// Randomised scoreboard bench for imem_param against a word-array reference model.
module tb_imem_param;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] INIT   = 32'h0000_0013;
    localparam logic [31:0] LIMIT  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] A   = '0;
    logic [31:0] D;
    logic        misaligned;
    logic        out_of_range;
    logic        init_done;

    imem_param_if #(.DATA_W(DATA_W)) ldif ();

    always #5 clk = ~clk;

    imem_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_WORD(INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .D           (D),
        .misaligned  (misaligned),
        .out_of_range(out_of_range),
        .init_done   (init_done),
        .ld          (ldif.slave)
    );

    // Reference model: contents as words, clear progress as an edge count.
    logic [31:0] mem_m [DEPTH];
    int          clr_cnt = 0;
    bit          done_m  = 1'b0;
    bit          err_m   = 1'b0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] d;
        bit          mis;
        bit          oor;
        bit          done;
        bit          rdy;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_probe = 0;

    function automatic exp_t predict(input logic [31:0] a);
        exp_t e;
        e.id   = n_probe;
        e.a    = a;
        e.mis  = (a % 4) != 0;
        e.oor  = (a >= LIMIT);
        e.done = done_m;
        e.rdy  = done_m;
        e.err  = err_m;
        if (!done_m || e.oor) e.d = INIT;
        else                  e.d = mem_m[int'(a / 4)];
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) < 8) return 32'($urandom_range(0, DEPTH - 1) * 4);
        return 32'($urandom_range(0, 32'h4FF));
    endfunction

    // One clock cycle: drive inputs, post the expected outputs, then advance
    // the model by whatever the coming edge is supposed to do.
    task automatic cycle(input bit r, input logic [31:0] a, input bit v,
                         input logic [31:0] la, input logic [31:0] ldt);
        rst = r;
        if (!r) begin
            clr_cnt = 0;
            done_m  = 1'b0;
            err_m   = 1'b0;
        end
        A             = a;
        ldif.ld_valid = v;
        ldif.ld_addr  = la;
        ldif.ld_data  = ldt;
        sb.push_back(predict(a));
        n_probe++;
        @(posedge clk);
        if (r) begin
            if (!done_m) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) begin
                    done_m = 1'b1;
                    foreach (mem_m[i]) mem_m[i] = INIT;
                end
            end else if (v) begin
                if ((la % 4) == 0 && la < LIMIT) mem_m[int'(la / 4)] = ldt;
                else                             err_m = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] a);
        cycle(1'b1, a, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] req, input exp_t e);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s probe=%0d A=0x%08h actual=0x%08h required=0x%08h",
                     nm, e.id, e.a, act, req);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("D",            D,                    e.d,          e);
            chk("misaligned",   32'(misaligned),      32'(e.mis),   e);
            chk("out_of_range", 32'(out_of_range),    32'(e.oor),   e);
            chk("init_done",    32'(init_done),       32'(e.done),  e);
            chk("ld_ready",     32'(ldif.ld_ready),   32'(e.rdy),   e);
            chk("ld_err",       32'(ldif.ld_err),     32'(e.err),   e);
            $display("probe %0d A=0x%08h D=0x%08h done=%0b rdy=%0b err=%0b",
                     e.id, e.a, D, init_done, ldif.ld_ready, ldif.ld_err);
        end
    end

    initial begin
        ldif.ld_valid = 1'b0;
        ldif.ld_addr  = '0;
        ldif.ld_data  = '0;
        @(posedge clk);
        #1;

        // Reset held for 3 cycles, then the full clear with ignored load attempts
        repeat (3) cycle(1'b0, rand_addr(), 1'b1, rand_addr(), $urandom());
        repeat (DEPTH) cycle(1'b1, rand_addr(), 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4));

        // Back-to-back loads, then fetch them
        cycle(1'b1, 32'h0, 1'b1, 32'h0, 32'h0050_0093);
        cycle(1'b1, 32'h4, 1'b1, 32'h4, 32'h0010_0113);
        idle(32'h0);
        idle(32'h4);

        // Rejected loads: misaligned, then out of range
        cycle(1'b1, 32'h4, 1'b1, 32'h6,   32'hBAD0_BAD0);
        cycle(1'b1, 32'h0, 1'b1, 32'h400, 32'hBAD1_BAD1);
        idle(32'h4);
        idle(32'h0);
        idle(32'h400);

        // Fetch flags
        idle(32'h402);
        idle(32'h5);

        // Read during write, then two writes to one word in consecutive cycles
        cycle(1'b1, 32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF);
        idle(32'h8);
        cycle(1'b1, 32'hC, 1'b1, 32'hC, 32'h1111_1111);
        cycle(1'b1, 32'hC, 1'b1, 32'hC, 32'h2222_2222);
        idle(32'hC);

        repeat (300) cycle(1'b1, rand_addr(), 1'($urandom_range(0, 1)), rand_addr(), $urandom());

        // Reset mid-clear at index 100, released two cycles later
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (100) cycle(1'b1, rand_addr(), 1'b1, rand_addr(), $urandom());
        repeat (2) cycle(1'b0, rand_addr(), 1'b1, rand_addr(), $urandom());
        repeat (DEPTH) cycle(1'b1, rand_addr(), 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4));

        repeat (200) cycle(1'b1, rand_addr(), 1'($urandom_range(0, 1)), rand_addr(), $urandom());

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
